// File: rtl/max_pool_layer_s4_if.sv
// Start/done handshake plus the flat feature and pooled-result buses of the S4 pooling stage.
interface max_pool_layer_s4_if #(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 10,
    parameter int W          = 10,
    parameter int channel    = 16
);
    localparam int FEAT_W = channel * H * W * DATA_WIDTH;
    localparam int OUT_W  = channel * (H / 2) * (W / 2) * DATA_WIDTH;

    logic              start;
    logic [FEAT_W-1:0] feature;
    logic [OUT_W-1:0]  pool_out;
    logic              busy;
    logic              done;

    modport master (output start, feature, input pool_out, busy, done);
    modport slave  (input start, feature, output pool_out, busy, done);
endinterface

// File: rtl/max_pool_layer_s4.sv
// LeNet S4 stage: per-channel 2x2 stride-2 FP16 max pooling with optional ReLU,
// one pooled element written per clock under a start/done handshake.
module max_pool_layer_s4 #(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 10,
    parameter int W          = 10,
    parameter int channel    = 16,
    parameter bit RELU       = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    max_pool_layer_s4_if.slave  bus
);
    localparam int HO     = H / 2;
    localparam int WO     = W / 2;
    localparam int N      = channel * HO * WO;
    localparam int FEAT_W = channel * H * W * DATA_WIDTH;
    localparam int OUT_W  = N * DATA_WIDTH;
    localparam int CW     = (channel > 1) ? $clog2(channel) : 1;
    localparam int RW     = (HO > 1) ? $clog2(HO) : 1;
    localparam int XW     = (WO > 1) ? $clog2(WO) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(channel - 1);
    localparam logic [RW-1:0] R_LAST = RW'(HO - 1);
    localparam logic [XW-1:0] X_LAST = XW'(WO - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic                  capture, last;
    logic [CW-1:0]         c_q, c_d;
    logic [RW-1:0]         r_q, r_d;
    logic [XW-1:0]         x_q, x_d;
    logic [FEAT_W-1:0]     feat_q;
    logic [OUT_W-1:0]      pool_q;
    logic                  done_q;
    int                    in_base, out_idx;
    logic [DATA_WIDTH-1:0] win0, win1, win2, win3;
    logic [DATA_WIDTH-1:0] max01, max23, max_all, result;

    // Monotonic unsigned key: negatives invert, positives set the top bit.
    function automatic logic [DATA_WIDTH-1:0] fp_key(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? ~v : {1'b1, v[DATA_WIDTH-2:0]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d = state_q;
        capture = 1'b0;
        last    = 1'b0;
        c_d     = c_q;
        r_d     = r_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    c_d     = '0;
                    r_d     = '0;
                    x_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                last = (c_q == C_LAST) && (r_q == R_LAST) && (x_q == X_LAST);
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (r_q == R_LAST) begin
                        r_d = '0;
                        c_d = c_q + 1'b1;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
                if (last) begin
                    c_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window mux from the captured frame, then a 4-input compare tree; earlier element wins ties.
    always_comb begin
        in_base = int'(c_q) * H * W + 2 * int'(r_q) * W + 2 * int'(x_q);
        out_idx = int'(c_q) * HO * WO + int'(r_q) * WO + int'(x_q);
        win0    = feat_q[in_base * DATA_WIDTH +: DATA_WIDTH];
        win1    = feat_q[(in_base + 1) * DATA_WIDTH +: DATA_WIDTH];
        win2    = feat_q[(in_base + W) * DATA_WIDTH +: DATA_WIDTH];
        win3    = feat_q[(in_base + W + 1) * DATA_WIDTH +: DATA_WIDTH];
        max01   = (fp_key(win1) > fp_key(win0)) ? win1 : win0;
        max23   = (fp_key(win3) > fp_key(win2)) ? win3 : win2;
        max_all = (fp_key(max23) > fp_key(max01)) ? max23 : max01;
        result  = (RELU && max_all[DATA_WIDTH-1]) ? '0 : max_all;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q    <= '0;
            r_q    <= '0;
            x_q    <= '0;
            pool_q <= '0;
            done_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            r_q    <= r_d;
            x_q    <= x_d;
            done_q <= last;
            if (state_q == RUN) pool_q[out_idx * DATA_WIDTH +: DATA_WIDTH] <= result;
        end
    end

    // NOTE: the captured frame has no reset; it is only read in RUN, after a capture has loaded it.
    always_ff @(posedge clk) begin
        if (capture) feat_q <= bus.feature;
    end

    assign bus.pool_out = pool_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_max_pool_layer_s4.sv
// Scoreboard bench for max_pool_layer_s4: one DUT with ReLU bypassed, one with ReLU enabled,
// both fed the same stimulus; a monitor pops expected frames on every done pulse.
module tb_max_pool_layer_s4;
    localparam int DW     = 16;
    localparam int H      = 10;
    localparam int W      = 10;
    localparam int CH     = 16;
    localparam int HO     = H / 2;
    localparam int WO     = W / 2;
    localparam int N      = CH * HO * WO;
    localparam int FEAT_W = CH * H * W * DW;
    localparam int OUT_W  = N * DW;

    typedef struct {
        int          c, r, x;
        logic [15:0] a, b, cc, d;
        logic [15:0] e0, e1;
    } win_t;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [FEAT_W-1:0] feat  = '0;
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    logic [OUT_W-1:0]  sb0[$];
    logic [OUT_W-1:0]  sb1[$];
    win_t              dir[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    max_pool_layer_s4_if #(.DATA_WIDTH(DW), .H(H), .W(W), .channel(CH)) bus0 ();
    max_pool_layer_s4_if #(.DATA_WIDTH(DW), .H(H), .W(W), .channel(CH)) bus1 ();

    assign bus0.start   = start;
    assign bus0.feature = feat;
    assign bus1.start   = start;
    assign bus1.feature = feat;

    max_pool_layer_s4 #(.DATA_WIDTH(DW), .H(H), .W(W), .channel(CH), .RELU(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    max_pool_layer_s4 #(.DATA_WIDTH(DW), .H(H), .W(W), .channel(CH), .RELU(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Sign/magnitude formulation of FP16 ordering: positive beats negative,
    // larger magnitude wins among positives, smaller magnitude among negatives.
    function automatic bit beats(input logic [15:0] n, input logic [15:0] cur);
        if (n[15] != cur[15]) return !n[15];
        if (!n[15]) return n[14:0] > cur[14:0];
        return n[14:0] < cur[14:0];
    endfunction

    function automatic logic [OUT_W-1:0] model(input logic [FEAT_W-1:0] f, input bit relu);
        logic [OUT_W-1:0] res;
        logic [15:0]      cand[4];
        logic [15:0]      best;
        int               base;
        res = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < HO; r++)
                for (int x = 0; x < WO; x++) begin
                    base    = c * H * W + 2 * r * W + 2 * x;
                    cand[0] = f[base * DW +: DW];
                    cand[1] = f[(base + 1) * DW +: DW];
                    cand[2] = f[(base + W) * DW +: DW];
                    cand[3] = f[(base + W + 1) * DW +: DW];
                    best    = cand[0];
                    for (int k = 1; k < 4; k++)
                        if (beats(cand[k], best)) best = cand[k];
                    if (relu && best[15]) best = 16'h0000;
                    res[(c * HO * WO + r * WO + x) * DW +: DW] = best;
                end
        return res;
    endfunction

    task automatic score(input bit relu, input logic [OUT_W-1:0] act);
        logic [OUT_W-1:0] exp;
        int               pending;
        pending = relu ? sb1.size() : sb0.size();
        check($sformatf("relu%0d done with pass pending", relu), 32'(pending != 0), 32'd1);
        if (pending == 0) return;
        exp = relu ? sb1.pop_front() : sb0.pop_front();
        for (int o = 0; o < N; o++)
            check($sformatf("relu%0d pool_out[%0d]", relu, o), 32'(act[o * DW +: DW]), 32'(exp[o * DW +: DW]));
    endtask

    always @(negedge clk) begin
        if (reset && bus0.done) score(1'b0, bus0.pool_out);
        if (reset && bus1.done) score(1'b1, bus1.pool_out);
    end

    task automatic fill_random();
        for (int i = 0; i < CH * H * W; i++) feat[i * DW +: DW] = 16'($urandom);
    endtask

    task automatic apply_dir();
        int base;
        for (int k = 0; k < 8; k++) begin
            base = dir[k].c * H * W + 2 * dir[k].r * W + 2 * dir[k].x;
            feat[base * DW +: DW]           = dir[k].a;
            feat[(base + 1) * DW +: DW]     = dir[k].b;
            feat[(base + W) * DW +: DW]     = dir[k].cc;
            feat[(base + W + 1) * DW +: DW] = dir[k].d;
        end
    endtask

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb0.push_back(model(feat, 1'b0));
        sb1.push_back(model(feat, 1'b1));
    endtask

    // Called just after the accepting edge; returns edges until done is seen and busy cycles.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = bus0.busy ? 1 : 0;
        forever begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus0.done) return;
            if (bus0.busy) busy_cnt++;
            if (edges > 2 * N) begin
                check("wait for done within budget", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    initial begin
        int          edges, busy_cnt, d1, d2, o;
        logic [OUT_W-1:0] junk;

        dir[0] = '{0, 0, 0, 16'h3C00, 16'h4000, 16'hBC00, 16'h3800, 16'h4000, 16'h4000};
        dir[1] = '{0, 0, 1, 16'hC000, 16'hBC00, 16'hC400, 16'hC200, 16'hBC00, 16'h0000};
        dir[2] = '{0, 0, 2, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
        dir[3] = '{0, 0, 3, 16'h3C00, 16'h3C00, 16'h3800, 16'h3800, 16'h3C00, 16'h3C00};
        dir[4] = '{0, 1, 0, 16'hFE00, 16'hFC00, 16'h8001, 16'h8000, 16'h8000, 16'h0000};
        dir[5] = '{15, 4, 4, 16'h7C00, 16'h7E00, 16'hFC00, 16'h0000, 16'h7E00, 16'h7E00};
        dir[6] = '{7, 2, 3, 16'h0001, 16'h8000, 16'h0000, 16'h3BFF, 16'h3BFF, 16'h3BFF};
        dir[7] = '{3, 0, 4, 16'hBC00, 16'hC000, 16'hC400, 16'hC200, 16'hBC00, 16'h0000};

        // Reset held with start toggling: everything stays cleared.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
        end
        start = 1'b0;
        check("reset pool_out relu0", 32'(|bus0.pool_out), 32'd0);
        check("reset pool_out relu1", 32'(|bus1.pool_out), 32'd0);
        check("reset busy", 32'(bus0.busy), 32'd0);
        check("reset done", 32'(bus0.done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle after reset busy", 32'(bus0.busy), 32'd0);
            check("idle after reset done", 32'(bus0.done), 32'd0);
        end

        // Pass 1: directed windows over random data, plus an ignored mid-pass start.
        fill_random();
        apply_dir();
        start_pass();
        fork
            begin
                repeat (100) @(negedge clk);
                start = 1'b1;
                feat  = ~feat;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        wait_done(edges, busy_cnt);
        check("pass1 latency edges", 32'(edges), 32'(N));
        check("pass1 busy cycles", 32'(busy_cnt), 32'(N));
        check("pass1 relu1 done aligned", 32'(bus1.done), 32'd1);
        for (int k = 0; k < 8; k++) begin
            o = dir[k].c * HO * WO + dir[k].r * WO + dir[k].x;
            check($sformatf("window%0d relu0", k), 32'(bus0.pool_out[o * DW +: DW]), 32'(dir[k].e0));
            check($sformatf("window%0d relu1", k), 32'(bus1.pool_out[o * DW +: DW]), 32'(dir[k].e1));
        end
        @(negedge clk);
        check("done is a single-cycle pulse", 32'(bus0.done), 32'd0);
        repeat (30) @(negedge clk);
        check("idle after pass1", 32'(bus0.busy), 32'd0);

        // Back-to-back: start held through done; the second pass captures a fresh frame.
        fill_random();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        sb0.push_back(model(feat, 1'b0));
        sb1.push_back(model(feat, 1'b1));
        fill_random();
        wait_done(edges, busy_cnt);
        d1 = cyc;
        check("b2b first latency", 32'(edges), 32'(N));
        @(posedge clk);
        #1;
        sb0.push_back(model(feat, 1'b0));
        sb1.push_back(model(feat, 1'b1));
        check("b2b second pass accepted", 32'(bus0.busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, busy_cnt);
        d2 = cyc;
        // Start is sampled on the edge after the done cycle, so pulses sit N+1 edges apart.
        check("b2b done spacing", 32'(d2 - d1), 32'(N + 1));
        check("b2b second busy cycles", 32'(busy_cnt), 32'(N));
        repeat (5) @(negedge clk);
        check("no third pass", 32'(bus0.busy), 32'd0);

        // Reset mid-pass discards the partial result; a restart completes normally.
        fill_random();
        start_pass();
        repeat (150) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midpass reset pool_out relu0", 32'(|bus0.pool_out), 32'd0);
        check("midpass reset pool_out relu1", 32'(|bus1.pool_out), 32'd0);
        check("midpass reset busy", 32'(bus0.busy), 32'd0);
        check("midpass reset done", 32'(bus0.done), 32'd0);
        junk = sb0.pop_back();
        junk = sb1.pop_back();
        @(negedge clk);
        reset = 1'b1;
        start_pass();
        wait_done(edges, busy_cnt);
        check("restart latency", 32'(edges), 32'(N));
        repeat (3) @(negedge clk);
        check("scoreboard relu0 drained", 32'(sb0.size()), 32'd0);
        check("scoreboard relu1 drained", 32'(sb1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
